logic_unit_sequencer: RTL and testbench

- Bit-serial logic unit shared between two requesters (requester 0 and requester 1). One 1-bit AND/OR/XOR/XNOR slice is time-multiplexed across WIDTH cycles.
- Arbitration between the requesters is round-robin. Each requester uses a valid/ready request handshake, and both share one valid/ready result channel.
- Sits beside the ALU as a low-area logic path for non-critical datapath operations, such as flag and mask computation.

---
 rtl/logic_unit_sequencer.sv | 139 +++++++++++++
 tb/tb_logic_unit_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_sequencer.sv
// Bit-serial AND/OR/XOR/XNOR unit shared by two requesters with round-robin arbitration.
// One 1-bit slice processes the operands LSB first over WIDTH cycles and then holds the result.
module logic_unit_sequencer #(
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             ptr_reg;
  logic [1:0]       op_reg;
  logic             id_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] r_sh_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic             res_id_reg;
  logic             res_zero_reg;

  logic             grant0;
  logic             grant1;
  logic             take;
  logic             last_bit;
  logic             r_bit;
  logic [WIDTH-1:0] r_sh_next;

  function automatic logic op_bit(input logic [1:0] op, input logic a, input logic b);
    logic r;
    unique case (op)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: r = a ^ b;
      2'b11: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  // ptr_reg == 0 favours requester 0 when both are valid
  assign grant0 = req0_valid & (~req1_valid | ~ptr_reg);
  assign grant1 = req1_valid & (~req0_valid |  ptr_reg);

  assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
  assign r_bit     = op_bit(op_reg, a_sh_reg[0], b_sh_reg[0]);
  assign r_sh_next = {r_bit, r_sh_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (grant0 | grant1) begin
          state_next = RUN;
          take       = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg      <= 1'b0;
      op_reg       <= 2'b00;
      id_reg       <= 1'b0;
      cnt_reg      <= '0;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      r_sh_reg     <= '0;
      res_data_reg <= '0;
      res_id_reg   <= 1'b0;
      res_zero_reg <= 1'b0;
    end else if (take) begin
      op_reg   <= grant1 ? req1_op : req0_op;
      a_sh_reg <= grant1 ? req1_a  : req0_a;
      b_sh_reg <= grant1 ? req1_b  : req0_b;
      id_reg   <= grant1;
      ptr_reg  <= ~grant1;
      cnt_reg  <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg <= a_sh_reg >> 1;
      b_sh_reg <= b_sh_reg >> 1;
      r_sh_reg <= r_sh_next;
      cnt_reg  <= cnt_reg + CW'(1);
      // The result registers only change on the final bit, so res_data survives the next RUN
      if (last_bit) begin
        res_data_reg <= r_sh_next;
        res_zero_reg <= ~|r_sh_next;
        res_id_reg   <= id_reg;
      end
    end
  end

  // Readies are masked by reset so that every output is low while reset is held
  assign req0_ready = (state_reg == IDLE) & grant0 & ~reset;
  assign req1_ready = (state_reg == IDLE) & grant1 & ~reset;
  assign res_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign res_data   = res_data_reg;
  assign res_id     = res_id_reg;
  assign res_zero   = res_zero_reg;

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Self-checking bench for logic_unit_sequencer (WIDTH=8): vector table plus corner-case sequences,
// with a scoreboard of expected results filled on accept and drained on result handshake.
module tb_logic_unit_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_data;
  logic         res_id, res_zero, busy;

  logic_unit_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .res_zero(res_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         zero;
  } vec_t;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  int           accepts[$];
  int           grants[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           r0_pulses = 0;
  logic [W-1:0] last_data;
  logic         last_zero;

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observe handshakes just before the edge that completes them, then advance one cycle
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      check_b("single_ready", req0_ready & req1_ready, 1'b0);
      if (busy) check_b("ready_while_busy", req0_ready | req1_ready, 1'b0);
      if (req0_ready) r0_pulses++;
      if (req0_valid && req0_ready) begin
        e.id = 1'b0; e.data = model(req0_op, req0_a, req0_b);
        sb.push_back(e); grants.push_back(0); accepts.push_back(cyc);
        $display("cycle %0d: accept id=0 op=%0d a=0x%0h b=0x%0h", cyc, req0_op, req0_a, req0_b);
      end
      if (req1_valid && req1_ready) begin
        e.id = 1'b1; e.data = model(req1_op, req1_a, req1_b);
        sb.push_back(e); grants.push_back(1); accepts.push_back(cyc);
        $display("cycle %0d: accept id=1 op=%0d a=0x%0h b=0x%0h", cyc, req1_op, req1_a, req1_b);
      end
      if (res_valid && res_ready) begin
        $display("cycle %0d: result id=%0d data=0x%0h zero=%0b", cyc, res_id, res_data, res_zero);
        last_data = res_data;
        last_zero = res_zero;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got data 0x%0h, required no result", res_data);
        end else begin
          e = sb.pop_front();
          check_v("res_data", res_data, e.data);
          check_b("res_id", res_id, e.id);
          check_b("res_zero", res_zero, ~|e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n0;
    int k;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    n0 = accepts.size();
    k  = 0;
    while (accepts.size() == n0 && k < 40) begin tick(); k++; end
    if (accepts.size() == n0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept, required one within 40 cycles");
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 80) begin tick(); k++; end
    if (sb.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!res_valid && k < 40) begin tick(); k++; end
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got res_valid=0, required 1 within 40 cycles");
    end
  endtask

  task automatic check_reset_outputs();
    check_b("rst_req0_ready", req0_ready, 1'b0);
    check_b("rst_req1_ready", req1_ready, 1'b0);
    check_b("rst_res_valid", res_valid, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_v("rst_res_data", res_data, '0);
    check_b("rst_res_id", res_id, 1'b0);
    check_b("rst_res_zero", res_zero, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete(); accepts.delete(); grants.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int a0;
    logic [W-1:0] hold_data;
    logic hold_id, hold_zero;

    vecs[0] = '{2'b10, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    vecs[1] = '{2'b00, 8'hA5, 8'h0F, 8'h05, 1'b0};
    vecs[2] = '{2'b01, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[3] = '{2'b10, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    vecs[4] = '{2'b11, 8'hA5, 8'h0F, 8'h55, 1'b0};
    vecs[5] = '{2'b00, 8'hA5, 8'h5A, 8'h00, 1'b1};

    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; res_ready = 0;
    do_reset();

    // Single XOR: one ready pulse, WIDTH-cycle latency, busy drops after handshake
    res_ready = 1'b1;
    r0_pulses = 0;
    send(1'b0, 2'b10, 8'hF0, 8'h3C);
    a0 = accepts[0];
    wait_valid();
    check_i("latency", cyc - 1 - a0, W);
    tick();
    check_b("busy_after_handshake", busy, 1'b0);
    check_i("req0_ready_pulses", r0_pulses, 1);
    check_v("xor_data", last_data, 8'hCC);

    // Opcode table
    foreach (vecs[i]) begin
      send(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      drain();
      check_v("table_data", last_data, vecs[i].exp);
      check_b("table_zero", last_zero, vecs[i].zero);
    end

    // Both requesters continuously valid: alternate grants, WIDTH+2 spacing
    do_reset();
    req0_op = 2'b01; req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1;
    req1_op = 2'b00; req1_a = 8'hFF; req1_b = 8'h81; req1_valid = 1'b1;
    for (int k = 0; k < 60 && accepts.size() < 3; k++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_i("accept_count", accepts.size(), 3);
    if (accepts.size() >= 3) begin
      check_i("grant0", grants[0], 0);
      check_i("grant1", grants[1], 1);
      check_i("grant2", grants[2], 0);
      check_i("spacing01", accepts[1] - accepts[0], W + 2);
      check_i("spacing12", accepts[2] - accepts[1], W + 2);
    end
    drain();

    // Result backpressure: outputs hold, nobody is accepted
    res_ready = 1'b0;
    send(1'b0, 2'b11, 8'h3C, 8'h0F);
    req1_op = 2'b01; req1_a = 8'h10; req1_b = 8'h20; req1_valid = 1'b1;
    wait_valid();
    hold_data = res_data; hold_id = res_id; hold_zero = res_zero;
    check_v("stall_data_model", hold_data, 8'hCC);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_b("stall_valid", res_valid, 1'b1);
      check_v("stall_data", res_data, hold_data);
      check_b("stall_id", res_id, hold_id);
      check_b("stall_zero", res_zero, hold_zero);
      check_b("stall_no_ready", req0_ready | req1_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    check_b("idle_after_release", busy, 1'b0);
    send(1'b1, 2'b01, 8'h10, 8'h20);
    drain();

    // Operands changed during RUN do not affect the result
    send(1'b0, 2'b10, 8'h96, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      tick();
    end
    drain();
    check_v("latched_operands", last_data, 8'h99);

    // Reset mid-RUN: outputs drop at once; afterwards requester 0 wins
    send(1'b0, 2'b01, 8'h12, 8'h34);
    repeat (3) tick();
    req0_op = 2'b00; req0_a = 8'hF3; req0_b = 8'h3F; req0_valid = 1'b1;
    req1_op = 2'b10; req1_a = 8'h11; req1_b = 8'h22; req1_valid = 1'b1;
    do_reset();
    for (int k = 0; k < 10 && accepts.size() < 1; k++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_i("post_reset_accepts", accepts.size(), 1);
    if (accepts.size() >= 1) check_i("post_reset_grant", grants[0], 0);
    drain();
    check_v("post_reset_data", last_data, 8'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
